// File: rtl/sram_burst_master.sv
// Host-facing burst master for an 8-bit single-port SRAM with a level-sensitive write strobe.
// Every write beat is sequenced as setup / strobe / hold so address and data never move under EN.
module sram_burst_master #(
    parameter int DEPTH = 11,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [3:0]    req_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_in_data,
    output logic          mem_en,
    input  logic [DW-1:0] mem_out_data
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
    // ready never depends on valid, and a producer holds valid/data until the transfer.

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_WAIT   = 3'd1,
        W_SETUP  = 3'd2,
        W_STROBE = 3'd3,
        W_HOLD   = 3'd4,
        R_SETUP  = 3'd5,
        R_DATA   = 3'd6,
        FIN      = 3'd7
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] addr_next;
    logic [4:0]    count;
    logic          err_flag;
    logic          start_bad;
    logic          last_beat;

    assign start_bad = (req_addr >= AW'(DEPTH));
    assign last_beat = (count == 5'd1);
    assign addr_next = (cur_addr == AW'(DEPTH - 1)) ? '0 : cur_addr + AW'(1);

    assign req_ready = (state == IDLE);
    assign wr_ready  = (state == W_WAIT);
    assign rd_valid  = (state == R_DATA);
    assign done      = (state == FIN);
    assign err       = (state == FIN) && err_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (start_bad) begin
                        state_nx = FIN;
                    end else if (req_write) begin
                        state_nx = W_WAIT;
                    end else begin
                        state_nx = R_SETUP;
                    end
                end
            end
            W_WAIT:   if (wr_valid) state_nx = W_SETUP;
            W_SETUP:  state_nx = W_STROBE;
            W_STROBE: state_nx = W_HOLD;
            W_HOLD:   state_nx = last_beat ? FIN : W_WAIT;
            R_SETUP:  state_nx = R_DATA;
            R_DATA:   if (rd_ready) state_nx = last_beat ? FIN : R_SETUP;
            FIN:      state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // mem_en is a flop with async clear so it drops the instant rst_n falls
    // and cannot glitch from state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en      <= 1'b0;
            mem_address <= '0;
            mem_in_data <= '0;
            rd_data     <= '0;
            cur_addr    <= '0;
            count       <= '0;
            err_flag    <= 1'b0;
        end else begin
            mem_en <= (state_nx == W_STROBE);
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr <= req_addr;
                        count    <= {1'b0, req_len} + 5'd1;
                        err_flag <= start_bad;
                        // Reads present the address one cycle ahead of the capture edge.
                        if (!start_bad && !req_write) begin
                            mem_address <= req_addr;
                        end
                    end
                end
                W_WAIT: begin
                    if (wr_valid) begin
                        mem_address <= cur_addr;
                        mem_in_data <= wr_data;
                    end
                end
                W_HOLD: begin
                    cur_addr <= addr_next;
                    count    <= count - 5'd1;
                end
                R_SETUP: begin
                    rd_data <= mem_out_data;
                end
                R_DATA: begin
                    if (rd_ready) begin
                        cur_addr <= addr_next;
                        count    <= count - 5'd1;
                        if (!last_beat) begin
                            mem_address <= addr_next;
                        end
                    end
                end
                FIN: begin
                    err_flag <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_master.sv
// Directed bench for sram_burst_master with a behavioural SRAM, a write log and a strobe-stability monitor.
module tb_sram_burst_master;

    localparam int DEPTH = 11;
    localparam int AW    = 8;
    localparam int DW    = 8;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          err;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_in_data;
    logic          mem_en;
    logic [DW-1:0] mem_out_data;

    logic [DW-1:0]    mem [0:DEPTH-1];
    logic [AW+DW-1:0] wr_log[$];
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    got_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int glitch_cnt   = 0;

    sram_burst_master #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .done         (done),
        .err          (err),
        .mem_address  (mem_address),
        .mem_in_data  (mem_in_data),
        .mem_en       (mem_en),
        .mem_out_data (mem_out_data)
    );

    // ---------------- clock / SRAM model / monitors ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_out_data = (mem_address < AW'(DEPTH)) ? mem[mem_address[3:0]] : '0;

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            mem[mem_address[3:0]] <= mem_in_data;
            wr_log.push_back({mem_address, mem_in_data});
        end
        if (done === 1'b1) done_cnt++;
    end

    always @(mem_address or mem_in_data) begin
        if (mem_en === 1'b1) glitch_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [3:0] len);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drive_wbeat(input logic [DW-1:0] d, output bit timed_out);
        int n = 0;
        while (wr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        timed_out = (wr_ready !== 1'b1);
        wr_valid  = 1'b1;
        wr_data   = d;
        @(negedge clk);
        wr_valid  = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        timed_out = (done !== 1'b1);
    endtask

    task automatic wait_rd(output bit timed_out);
        int n = 0;
        while (rd_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        timed_out = (rd_valid !== 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests_run++;
        if ({req_ready, mem_en, wr_ready, rd_valid, done, err} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 100000", {req_ready, mem_en, wr_ready, rd_valid, done, err});
        end
        tests_run++;
        if ({mem_address, mem_in_data, rd_data} !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 000000", {mem_address, mem_in_data, rd_data});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({req_ready, mem_en, wr_ready, rd_valid, done, err, mem_address, mem_in_data, rd_data} !== {6'b100000, 24'h0}) begin
            tests_failed++;
            $display("FAIL post_reset: got %b_%h expected 100000_000000",
                     {req_ready, mem_en, wr_ready, rd_valid, done, err}, {mem_address, mem_in_data, rd_data});
        end
    endtask

    task automatic test_single();
        int d0;
        d0 = done_cnt;
        wr_log.delete();
        issue(1'b1, 8'd3, 4'd0);
        tests_run++;
        if ({wr_ready, mem_en, req_ready} !== 3'b100) begin
            tests_failed++;
            $display("FAIL single_wwait: got %b expected 100", {wr_ready, mem_en, req_ready});
        end
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        @(negedge clk);
        wr_valid = 1'b0;
        tests_run++;
        if ({mem_en, wr_ready, mem_address, mem_in_data} !== {2'b00, 8'd3, 8'hA5}) begin
            tests_failed++;
            $display("FAIL single_setup: got %b_%h_%h expected 00_03_a5", {mem_en, wr_ready}, mem_address, mem_in_data);
        end
        @(negedge clk);
        tests_run++;
        if ({mem_en, mem_address, mem_in_data} !== {1'b1, 8'd3, 8'hA5}) begin
            tests_failed++;
            $display("FAIL single_strobe: got %b_%h_%h expected 1_03_a5", mem_en, mem_address, mem_in_data);
        end
        @(negedge clk);
        tests_run++;
        if ({mem_en, mem_address, mem_in_data, done} !== {1'b0, 8'd3, 8'hA5, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_hold: got en=%b addr=%h data=%h done=%b expected 0_03_a5_0", mem_en, mem_address, mem_in_data, done);
        end
        @(negedge clk);
        tests_run++;
        if ({done, err, req_ready} !== 3'b100) begin
            tests_failed++;
            $display("FAIL single_wdone: got %b expected 100", {done, err, req_ready});
        end
        @(negedge clk);
        tests_run++;
        if (wr_log.size() != 1 || wr_log[0] !== {8'd3, 8'hA5}) begin
            tests_failed++;
            $display("FAIL single_wlog: got size=%0d first=%h expected size=1 first=03a5",
                     wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 16'hxxxx);
        end
        issue(1'b0, 8'd3, 4'd0);
        tests_run++;
        if (rd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_rlat1: got rd_valid=%b expected 0", rd_valid);
        end
        @(negedge clk);
        tests_run++;
        if ({rd_valid, rd_data} !== {1'b1, 8'hA5}) begin
            tests_failed++;
            $display("FAIL single_rlat2: got %b_%h expected 1_a5", rd_valid, rd_data);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        tests_run++;
        if ({done, err, rd_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL single_rdone: got %b expected 100", {done, err, rd_valid});
        end
        @(negedge clk);
        tests_run++;
        if (done_cnt - d0 != 2 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_donecnt: got pulses=%0d done=%b expected 2 and 0", done_cnt - d0, done);
        end
    endtask

    task automatic test_burst();
        logic [DW-1:0] wd [4];
        bit to;
        int cyc;
        int beats;
        int last_cyc;
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
        wr_log.delete();
        exp_q.delete();
        exp_q.push_back({8'd9, 8'h11});
        exp_q.push_back({8'd10, 8'h22});
        exp_q.push_back({8'd0, 8'h33});
        exp_q.push_back({8'd1, 8'h44});
        issue(1'b1, 8'd9, 4'd3);
        for (int i = 0; i < 4; i++) begin
            drive_wbeat(wd[i], to);
            tests_run++;
            if (to) begin
                tests_failed++;
                $display("FAIL burst_wready_%0d: got wr_ready timeout expected wr_ready=1", i);
            end
        end
        wait_done(to);
        tests_run++;
        if (to || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_wdone: got timeout=%0b err=%b expected 0 0", to, err);
        end
        @(negedge clk);
        tests_run++;
        if (wr_log.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL burst_wlog_size: got %0d expected %0d", wr_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (wr_log[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL burst_wlog_%0d: got %h expected %h", i, wr_log[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        issue(1'b0, 8'd9, 4'd3);
        rd_ready = 1'b1;
        cyc = 0;
        beats = 0;
        last_cyc = 0;
        while (beats < 4 && cyc < 40) begin
            if (rd_valid === 1'b1) begin
                got_q.push_back(rd_data);
                tests_run++;
                if ((beats == 0 && cyc != 1) || (beats > 0 && cyc - last_cyc != 2)) begin
                    tests_failed++;
                    $display("FAIL burst_rtiming_%0d: got cycle %0d (prev %0d) expected first at 1 then every 2", beats, cyc, last_cyc);
                end
                last_cyc = cyc;
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        rd_ready = 1'b0;
        tests_run++;
        if (done !== 1'b1 || beats != 4) begin
            tests_failed++;
            $display("FAIL burst_rdone: got done=%b beats=%0d expected 1 4", done, beats);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== wd[i]) begin
                tests_failed++;
                $display("FAIL burst_rdata_%0d: got %h expected %h", i, got_q[i], wd[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        bit to;
        int d0;
        d0 = done_cnt;
        issue(1'b0, 8'd9, 4'd2);
        wait_rd(to);
        tests_run++;
        if (to || rd_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL stall_beat1: got timeout=%0b data=%h expected 0 11", to, rd_data);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if ({rd_valid, rd_data, done} !== {1'b1, 8'h22, 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: got valid=%b data=%h done=%b expected 1 22 0", i, rd_valid, rd_data, done);
            end
            if (i < 5) @(negedge clk);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        tests_run++;
        if ({rd_valid, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL stall_gap: got valid=%b done=%b expected 0 0", rd_valid, done);
        end
        @(negedge clk);
        tests_run++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h33}) begin
            tests_failed++;
            $display("FAIL stall_beat3: got valid=%b data=%h expected 1 33", rd_valid, rd_data);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        tests_run++;
        if ({done, err, rd_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL stall_done: got %b expected 100", {done, err, rd_valid});
        end
        @(negedge clk);
        tests_run++;
        if (done_cnt - d0 != 1 || rd_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_after: got pulses=%0d valid=%b ready=%b expected 1 0 1", done_cnt - d0, rd_valid, req_ready);
        end
    endtask

    task automatic test_bad_addr();
        wr_log.delete();
        issue(1'b0, 8'd11, 4'd0);
        tests_run++;
        if ({done, err, rd_valid, mem_en, req_ready} !== 5'b11000) begin
            tests_failed++;
            $display("FAIL bad_rd: got %b expected 11000", {done, err, rd_valid, mem_en, req_ready});
        end
        @(negedge clk);
        tests_run++;
        if ({done, err, req_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL bad_rd_after: got %b expected 001", {done, err, req_ready});
        end
        issue(1'b1, 8'd12, 4'd3);
        tests_run++;
        if ({done, err, wr_ready, mem_en} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL bad_wr: got %b expected 1100", {done, err, wr_ready, mem_en});
        end
        @(negedge clk);
        tests_run++;
        if (wr_log.size() != 0 || {done, err, req_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL bad_wr_after: got writes=%0d flags=%b expected 0 001", wr_log.size(), {done, err, req_ready});
        end
    endtask

    task automatic test_reset_mid();
        wr_log.delete();
        issue(1'b1, 8'd5, 4'd2);
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({mem_en, mem_address} !== {1'b1, 8'd5}) begin
            tests_failed++;
            $display("FAIL rmid_strobe: got en=%b addr=%h expected 1 05", mem_en, mem_address);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_en, req_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rmid_async: got en=%b ready=%b expected 0 1", mem_en, req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        wr_valid = 1'b0;
        tests_run++;
        if (wr_log.size() != 0 || {req_ready, wr_ready, mem_en} !== 3'b100 || mem[5] !== 8'h00) begin
            tests_failed++;
            $display("FAIL rmid_after: got writes=%0d flags=%b mem5=%h expected 0 100 00",
                     wr_log.size(), {req_ready, wr_ready, mem_en}, mem[5]);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_bad_addr();
        test_reset_mid();

        tests_run++;
        if (glitch_cnt != 0) begin
            tests_failed++;
            $display("FAIL strobe_stable: got %0d pin changes while mem_en=1 expected 0", glitch_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
